// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM peripheral.
// Register index decode helpers operate on addr[23:16].
package pwm_pkg;

  localparam logic [7:0] GEN_A     = 8'h00;
  localparam logic [7:0] DONE_A    = 8'h01;
  localparam logic [7:0] CH_BASE   = 8'h10;
  localparam logic [7:0] CH_STRIDE = 8'd4;

  localparam logic [7:0] PER_O = 8'd0;
  localparam logic [7:0] DUT_O = 8'd1;
  localparam logic [7:0] CTL_O = 8'd2;
  localparam logic [7:0] CNT_O = 8'd3;

  localparam int INV_B     = 0;
  localparam int ONESHOT_B = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

  function automatic logic [7:0] ch_of(input logic [7:0] idx);
    return (idx - CH_BASE) / CH_STRIDE;
  endfunction

  function automatic logic [7:0] off_of(input logic [7:0] idx);
    return (idx - CH_BASE) % CH_STRIDE;
  endfunction

endpackage

// File: rtl/pwm_multi_chan.sv
// One PWM channel: IDLE/RUN state, counter, active period/duty and output flop.
// The output flop is fed from next-state values so pwm lines up with cnt.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] per_sh,
  input  logic [CNT_W-1:0] dut_sh,
  input  logic [1:0]       ctrl,
  output logic             pwm,
  output logic [CNT_W-1:0] cnt,
  output logic             done_pulse
);

  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  pwm_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] per_r, per_s;
  logic [CNT_W-1:0] dut_r, dut_s;
  logic             pwm_r;
  logic             done_s;
  logic             end_s;
  logic             lvl_s;

  // next-state, active-register reload and one-shot completion
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    per_s   = per_r;
    dut_s   = dut_r;
    done_s  = 1'b0;
    end_s   = (per_r != '0) && (cnt_r == (per_r - ONE_C));
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (en) begin
          state_s = RUN;
          per_s   = per_sh;
          dut_s   = dut_sh;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (per_r == '0) begin
          // zero period parks the counter until a usable shadow appears
          cnt_s = '0;
          if (per_sh != '0) begin
            per_s = per_sh;
            dut_s = dut_sh;
          end else begin
            per_s = per_r;
          end
        end else if (end_s) begin
          cnt_s = '0;
          per_s = per_sh;
          dut_s = dut_sh;
          if (ctrl[ONESHOT_B]) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = RUN;
          end
        end else begin
          cnt_s = cnt_r + ONE_C;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
    lvl_s = (state_s == RUN) && (per_s != '0) && (cnt_s < dut_s);
  end

  // channel state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      per_r   <= '0;
      dut_r   <= '0;
      pwm_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      per_r   <= per_s;
      dut_r   <= dut_s;
      pwm_r   <= lvl_s ^ ctrl[INV_B];
    end
  end

  assign pwm        = pwm_r;
  assign cnt        = cnt_r;
  assign done_pulse = done_s;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM peripheral: bus decode, shadow/GEN/DONE registers and read mux.
// Channels are instantiated from pwm_chan; shadows apply at each period boundary.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic [NUM_CH-1:0] pwm_o
);

  logic [7:0]        idx_s;
  logic [7:0]        ch_s;
  logic [7:0]        off_s;
  logic              ch_hit_s;
  logic [NUM_CH-1:0] wr_ch_s;
  logic [NUM_CH-1:0] gen_r;
  logic [NUM_CH-1:0] done_r;
  logic [NUM_CH-1:0] done_pulse_s;
  logic [CNT_W-1:0]  per_sh_r [NUM_CH];
  logic [CNT_W-1:0]  dut_sh_r [NUM_CH];
  logic [1:0]        ctl_r    [NUM_CH];
  logic [CNT_W-1:0]  cnt_s    [NUM_CH];
  logic [31:0]       ch_rd_s  [NUM_CH];
  logic [31:0]       rd_s;
  logic              unused_s;

  assign idx_s    = addr_i[23:16];
  assign ch_s     = ch_of(idx_s);
  assign off_s    = off_of(idx_s);
  assign ch_hit_s = (idx_s >= CH_BASE) && (ch_s < 8'(NUM_CH));
  assign unused_s = ^{addr_i[31:24], addr_i[15:0], data_i};

  // per-channel write strobes
  always_comb begin
    wr_ch_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ch_s[c] = we_i && ch_hit_s && (ch_s == 8'(c));
    end
  end

  // register file; software GEN writes win over one-shot clears, DONE sets win over W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_r  <= '0;
      done_r <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        per_sh_r[c] <= '0;
        dut_sh_r[c] <= '0;
        ctl_r[c]    <= 2'b00;
      end
    end else begin
      if (we_i && (idx_s == GEN_A)) begin
        gen_r <= data_i[NUM_CH-1:0];
      end else begin
        gen_r <= gen_r & ~done_pulse_s;
      end
      if (we_i && (idx_s == DONE_A)) begin
        done_r <= (done_r & ~data_i[NUM_CH-1:0]) | done_pulse_s;
      end else begin
        done_r <= done_r | done_pulse_s;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ch_s[c]) begin
          case (off_s)
            PER_O:   per_sh_r[c] <= data_i[CNT_W-1:0];
            DUT_O:   dut_sh_r[c] <= data_i[CNT_W-1:0];
            CTL_O:   ctl_r[c]    <= data_i[1:0];
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (gen_r[g]),
      .per_sh    (per_sh_r[g]),
      .dut_sh    (dut_sh_r[g]),
      .ctrl      (ctl_r[g]),
      .pwm       (pwm_o[g]),
      .cnt       (cnt_s[g]),
      .done_pulse(done_pulse_s[g])
    );
  end

  // per-channel register word selected by the offset
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      case (off_s)
        PER_O:   ch_rd_s[c] = 32'(per_sh_r[c]);
        DUT_O:   ch_rd_s[c] = 32'(dut_sh_r[c]);
        CTL_O:   ch_rd_s[c] = 32'(ctl_r[c]);
        CNT_O:   ch_rd_s[c] = 32'(cnt_s[c]);
        default: ch_rd_s[c] = 32'h0;
      endcase
    end
  end

  // read mux; forced to zero while in reset
  always_comb begin
    rd_s = 32'h0;
    if (rst) begin
      rd_s = 32'h0;
    end else if (idx_s == GEN_A) begin
      rd_s = 32'(gen_r);
    end else if (idx_s == DONE_A) begin
      rd_s = 32'(done_r);
    end else if (ch_hit_s) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_s = rd_s | ((ch_s == 8'(c)) ? ch_rd_s[c] : 32'h0);
      end
    end else begin
      rd_s = 32'h0;
    end
  end

  assign data_o = rd_s;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios with literal expectations,
// then randomized register traffic checked every cycle against a behavioural model.
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] data = 32'h0;
  logic [31:0] data_o;
  logic [3:0]  pwm_o;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // behavioural model state
  bit          m_run [4];
  int unsigned m_cnt [4];
  int unsigned m_per [4];
  int unsigned m_dut [4];
  int unsigned s_per [4];
  int unsigned s_dut [4];
  bit [1:0]    m_ctl [4];
  bit [3:0]    m_gen, m_done, m_pwm;

  pwm_multi #(.NUM_CH(4), .CNT_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .we_i  (we),
    .addr_i(addr),
    .data_i(data),
    .data_o(data_o),
    .pwm_o (pwm_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int idx, ch, off;
    idx = int'(a[23:16]);
    ch  = (idx - 16) / 4;
    off = (idx - 16) % 4;
    if (idx == 0) return 32'(m_gen);
    if (idx == 1) return 32'(m_done);
    if (idx < 16 || ch >= 4) return 32'h0;
    case (off)
      0: return s_per[ch];
      1: return s_dut[ch];
      2: return 32'(m_ctl[ch]);
      default: return m_cnt[ch];
    endcase
  endfunction

  // one clock edge of the specification's rules, using pre-edge register values
  task automatic model_step();
    bit [3:0] pulse;
    int idx, ch;
    bit active;
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        m_run[c] = 0; m_cnt[c] = 0; m_per[c] = 0; m_dut[c] = 0;
        s_per[c] = 0; s_dut[c] = 0; m_ctl[c] = 2'b00;
      end
      m_gen = 4'h0; m_done = 4'h0; m_pwm = 4'h0;
    end else begin
      pulse = 4'h0;
      for (int c = 0; c < 4; c++) begin
        if (!m_run[c]) begin
          m_cnt[c] = 0;
          if (m_gen[c]) begin
            m_run[c] = 1; m_per[c] = s_per[c]; m_dut[c] = s_dut[c];
          end
        end else if (!m_gen[c]) begin
          m_run[c] = 0; m_cnt[c] = 0;
        end else if (m_per[c] == 0) begin
          if (s_per[c] != 0) begin
            m_per[c] = s_per[c]; m_dut[c] = s_dut[c];
          end
        end else if (m_cnt[c] + 1 == m_per[c]) begin
          m_cnt[c] = 0; m_per[c] = s_per[c]; m_dut[c] = s_dut[c];
          if (m_ctl[c][1]) begin
            m_run[c] = 0; pulse[c] = 1'b1;
          end
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
        active = m_run[c] && (m_per[c] != 0) && (m_dut[c] >= m_per[c] || m_cnt[c] < m_dut[c]);
        m_pwm[c] = active ^ m_ctl[c][0];
      end
      idx = int'(addr[23:16]);
      ch  = (idx - 16) / 4;
      if (we && idx == 0) m_gen = data[3:0];
      else m_gen = m_gen & ~pulse;
      if (we && idx == 1) m_done = (m_done & ~data[3:0]) | pulse;
      else m_done = m_done | pulse;
      if (we && idx >= 16 && ch < 4) begin
        case ((idx - 16) % 4)
          0: s_per[ch] = data;
          1: s_dut[ch] = data;
          2: m_ctl[ch] = data[1:0];
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_on) begin
        check("pwm_o", 32'(pwm_o), 32'(m_pwm));
        check("data_o", data_o, rst ? 32'h0 : model_rd(addr));
      end
    end
  end

  task automatic tick(input bit rs, input bit w, input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    rst  = rs;
    we   = w;
    addr = {8'h00, idx, 16'h0000};
    data = d;
  endtask

  // drive a write late in the current cycle, after the sample point
  task automatic poke(input logic [7:0] idx, input logic [31:0] d);
    #1;
    we   = 1'b1;
    addr = {8'h00, idx, 16'h0000};
    data = d;
  endtask

  initial begin
    int hi;
    bit found;
    logic [31:0] ra, rd;
    logic [7:0] ix;

    tick(1'b1, 1'b0, 8'h13, 32'h0);
    tick(1'b1, 1'b0, 8'h13, 32'h0);
    #2;
    check("rst_pwm_init", 32'(pwm_o), 32'h0);
    check("rst_rd_init", data_o, 32'h0);
    chk_on = 1'b1;

    // ch0: period 10, duty 3
    tick(1'b0, 1'b1, 8'h10, 32'd10);
    tick(1'b0, 1'b1, 8'h11, 32'd3);
    tick(1'b0, 1'b1, 8'h00, 32'h1);
    tick(1'b0, 1'b0, 8'h13, 32'h0);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b0, 8'h13, 32'h0);
      #2;
      if (k == 0) check("cnt0_first", data_o, 32'd0);
      if (k == 0) check("pwm0_first", 32'(pwm_o[0]), 32'd1);
      if (k == 9) check("cnt0_last", data_o, 32'd9);
      hi = hi + int'(pwm_o[0]);
    end
    check("ch0_high_in_20", 32'(hi), 32'd6);

    // DUTY0=8 written at cnt=5
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1'b0, 1'b0, 8'h13, 32'h0);
      #2;
      if (data_o == 32'd5) found = 1'b1;
    end
    check("wait_cnt5", 32'(found), 32'd1);
    poke(8'h11, 32'd8);
    hi = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, 8'h13, 32'h0);
      #2;
      hi = hi + int'(pwm_o[0]);
    end
    check("ch0_tail_old_duty", 32'(hi), 32'd0);
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0, 8'h13, 32'h0);
      #2;
      hi = hi + int'(pwm_o[0]);
    end
    check("ch0_new_duty_high", 32'(hi), 32'd8);

    // ch1 one-shot
    tick(1'b0, 1'b1, 8'h16, 32'h2);
    tick(1'b0, 1'b1, 8'h14, 32'd4);
    tick(1'b0, 1'b1, 8'h15, 32'd2);
    tick(1'b0, 1'b1, 8'h00, 32'h3);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 1'b0, 8'h00, 32'h0);
      #2;
      hi = hi + int'(pwm_o[1]);
    end
    check("ch1_oneshot_high", 32'(hi), 32'd2);
    check("gen_after_oneshot", data_o, 32'h1);
    tick(1'b0, 1'b0, 8'h01, 32'h0);
    #2;
    check("done_after_oneshot", data_o, 32'h2);
    check("pwm1_after_oneshot", 32'(pwm_o[1]), 32'd0);
    tick(1'b0, 1'b1, 8'h01, 32'h2);
    tick(1'b0, 1'b0, 8'h01, 32'h0);
    #2;
    check("done_w1c", data_o, 32'h0);

    // ch2 inversion and duty boundaries
    tick(1'b0, 1'b1, 8'h1A, 32'h1);
    tick(1'b0, 1'b0, 8'h1A, 32'h0);
    tick(1'b0, 1'b0, 8'h1A, 32'h0);
    #2;
    check("ch2_inv_idle", 32'(pwm_o[2]), 32'd1);
    tick(1'b0, 1'b1, 8'h18, 32'd5);
    tick(1'b0, 1'b1, 8'h19, 32'd0);
    tick(1'b0, 1'b1, 8'h00, 32'h5);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 1'b0, 8'h00, 32'h0);
      #2;
      hi = hi + int'(pwm_o[2]);
    end
    check("ch2_duty0_inv", 32'(hi), 32'd8);
    tick(1'b0, 1'b1, 8'h19, 32'd20);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 8'h19, 32'h0);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 1'b0, 8'h19, 32'h0);
      #2;
      hi = hi + int'(pwm_o[2]);
    end
    check("ch2_full_duty_inv", 32'(hi), 32'd0);

    // ch3 zero period, then reset mid-run
    tick(1'b0, 1'b1, 8'h00, 32'hD);
    tick(1'b0, 1'b0, 8'h1F, 32'h0);
    tick(1'b0, 1'b0, 8'h1F, 32'h0);
    #2;
    check("ch3_per0_pwm", 32'(pwm_o[3]), 32'd0);
    check("ch3_per0_cnt", data_o, 32'd0);
    tick(1'b1, 1'b0, 8'h10, 32'h0);
    #2;
    check("rd_in_rst", data_o, 32'h0);
    tick(1'b1, 1'b0, 8'h10, 32'h0);
    #2;
    check("pwm_after_rst", 32'(pwm_o), 32'h0);
    tick(1'b0, 1'b0, 8'h10, 32'h0);
    #2;
    check("per0_after_rst", data_o, 32'h0);
    tick(1'b0, 1'b0, 8'h00, 32'h0);
    #2;
    check("gen_after_rst", data_o, 32'h0);
    tick(1'b0, 1'b0, 8'h1A, 32'h0);
    #2;
    check("ctl2_after_rst", data_o, 32'h0);

    // GEN write coinciding with ch0 one-shot completion
    tick(1'b0, 1'b1, 8'h12, 32'h2);
    tick(1'b0, 1'b1, 8'h10, 32'd3);
    tick(1'b0, 1'b1, 8'h11, 32'd1);
    tick(1'b0, 1'b1, 8'h00, 32'h1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1'b0, 1'b0, 8'h13, 32'h0);
      #2;
      if (data_o == 32'd2) found = 1'b1;
    end
    check("wait_cnt2", 32'(found), 32'd1);
    poke(8'h00, 32'h1);
    tick(1'b0, 1'b0, 8'h01, 32'h0);
    #2;
    check("done_set_with_gen", data_o, 32'h1);
    check("pwm0_idle_gap", 32'(pwm_o[0]), 32'd0);
    tick(1'b0, 1'b0, 8'h00, 32'h0);
    #2;
    check("gen_sw_wins", data_o, 32'h1);
    check("pwm0_rerun", 32'(pwm_o[0]), 32'd1);
    tick(1'b0, 1'b0, 8'h3F, 32'h0);
    #2;
    check("rd_unmapped_3f", data_o, 32'h0);
    tick(1'b0, 1'b1, 8'h20, 32'hFFFF);
    tick(1'b0, 1'b0, 8'h20, 32'h0);
    #2;
    check("rd_ch4_absent", data_o, 32'h0);

    // randomized traffic, checked each cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 19))
        0:       ix = 8'h00;
        1:       ix = 8'h01;
        18:      ix = 8'h20 + 8'($urandom_range(0, 3));
        19:      ix = 8'h3F;
        default: ix = 8'h10 + 8'($urandom_range(0, 15));
      endcase
      if (ix[1:0] == 2'd0 && ix >= 8'h10) rd = 32'($urandom_range(0, 12));
      else if (ix[1:0] == 2'd1 && ix >= 8'h10) rd = 32'($urandom_range(0, 14));
      else rd = $urandom;
      if ($urandom_range(0, 49) == 0) rd = $urandom;
      ra = $urandom;
      @(negedge clk);
      rst  = ($urandom_range(0, 599) == 0);
      we   = ($urandom_range(0, 3) == 0);
      addr = {ra[31:24], ix, ra[15:0]};
      data = rd;
    end
    tick(1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM peripheral on the core's slave bus, successor to the fixed 4-channel PWM. Each channel has a programmable period, duty and control word, double-buffered so that updates take effect only at a period boundary (glitch-free). Adds per-channel output inversion, a one-shot mode with sticky completion status, and counter readback. Register index is decoded from `addr_i[23:16]`, as in the existing peripherals.

## Interface
- `NUM_CH`, 4: channel count, 1..8.
- `CNT_W`, 32: counter, period and duty width, 8..32. Register bits above `CNT_W` are zero on read and ignored on write.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `we_i` input 1: write strobe, one write per asserted cycle.
- `addr_i` input 32: only `[23:16]` is decoded.
- `data_i` input 32: write data.
- `data_o` output 32: combinational read data for `addr_i`.
- `pwm_o` output `NUM_CH`: registered PWM outputs, bit `ch` belongs to channel `ch`.

## Operation
- Register map, by `addr_i[23:16]`:
  - 0x00 `GEN`: bit `ch` is the enable for channel `ch`; R/W.
  - 0x01 `DONE`: bit `ch` is the one-shot-complete flag; read; write 1 to clear.
  - Per channel, base = 0x10 + 4·ch:
    - +0 `PERIOD`, shadow, R/W.
    - +1 `DUTY`, shadow, R/W.
    - +2 `CTRL`: bit0 `INV`, bit1 `ONESHOT`; R/W; takes effect immediately.
    - +3 `COUNT`: read-only live counter.
- Unmapped addresses and channels ≥ `NUM_CH` read 0; writes to them are ignored.
- Reads of `PERIOD` and `DUTY` return the shadow value, not the active value.
- Per-channel states: `IDLE` and `RUN`.
  - `IDLE`: `cnt`=0; output at the idle level (`INV`).
  - `IDLE`→`RUN` when the enable bit is 1. Load `per_act`←`PERIOD` and `dut_act`←`DUTY`; `cnt`←0.
  - `RUN`, when `cnt` == `per_act`−1 (period end):
    - `cnt`←0 and reload both active registers from the shadows.
    - If `ONESHOT` is set: clear the enable bit, set the `DONE` bit, go to `IDLE`.
  - `RUN`, otherwise: `cnt`←`cnt`+1.
  - `RUN`→`IDLE` immediately when the enable bit is cleared, mid-period included. The output returns to the idle level on the next edge.
- Output level:
  - Active when in `RUN` and `cnt` < `dut_act`; otherwise inactive.
  - `pwm_o` = level XOR `INV`.
- Boundary cases:
  - `per_act`=0: the channel stays in `RUN` with `cnt` held at 0 and the output inactive. A nonzero shadow `PERIOD` is reloaded on every cycle while `per_act`=0.
  - `dut_act`=0: output always inactive.
  - `dut_act` ≥ `per_act`: output always active.
  - `per_act`=1: period end occurs every cycle.
- Simultaneous events:
  - A software write to `GEN` in the same cycle as a one-shot clear: the software value wins.
  - A `DONE` set in the same cycle as a W1C of that bit: the set wins.
- Reset: all registers, `cnt`, state and `DONE` go to 0; `pwm_o`=0. While `rst`=1, `data_o`=0.

## Timing
- A write sampled at edge E updates its register at E.
- A `GEN` enable written at E: the channel enters `RUN` at E+1, and `pwm_o` shows the first-period level from E+1.
- In steady state, `pwm_o` is active for exactly `dut_act` cycles in every `per_act` cycles.
- A `PERIOD`/`DUTY` write never alters the period in progress. It applies from the next period start.
- Disable written at E: the channel is `IDLE` and `pwm_o` is at the idle level from E+1.
- `INV` changes appear on `pwm_o` on the edge after the write.
- `COUNT` reads the registered `cnt` with zero-cycle read latency.
- `DONE` is set on the same edge at which the one-shot channel enters `IDLE`.

## Structure
- Shared package `pwm_pkg` holds:
  - Address constants `GEN_A`=0x00, `DONE_A`=0x01, `CH_BASE`=0x10, `CH_STRIDE`=4.
  - Per-channel offsets `PER_O`, `DUT_O`, `CTL_O`, `CNT_O`.
  - `CTRL` bit positions `INV_B`, `ONESHOT_B`.
  - The state encoding `IDLE`/`RUN`.
- Sub-module `pwm_chan`:
  - One per channel, instantiated `NUM_CH` times by generate loop.
  - Contains the state, counter, active registers and output flop.
  - Inputs: enable, shadows, `CTRL`. Outputs: `pwm`, `cnt`, `done_pulse`.
- Top level contains the bus decode, shadow/`GEN`/`DONE` registers and the read mux.

## Test plan
- Reset, then `PERIOD0`=10, `DUTY0`=3, `GEN`=0x1 → `pwm_o[0]` repeats 3 high / 7 low starting E+1; `COUNT0` walks 0..9.
- Mid-period, write `DUTY0`=8 at `cnt`=5 → current period keeps 3 high; next period 8 high / 2 low.
- `CTRL1`=`ONESHOT`, `PERIOD1`=4, `DUTY1`=2, `GEN`=0x2 → one 2-high/2-low pulse; then `GEN[1]`=0, `DONE[1]`=1, `pwm_o[1]` low. Write `DONE`=0x2 → `DONE` reads 0.
- `INV`=1 on ch2 while disabled → `pwm_o[2]`=1. `DUTY2`=0 enabled → stays 1. `DUTY2`=20 with `PERIOD2`=5 → constant 0 from next period.
- Enable ch3 with `PERIOD3`=0 → output inactive, `COUNT3`=0. Assert `rst` mid-run on all channels → next edge all outputs 0 and all registers 0.
- Write `GEN`=0x1 in the same cycle ch0's one-shot completes → ch0 re-enters `RUN`, `DONE[0]`=1. Read address 0x3F → 0.
